// File: rtl/minute_counter60.sv
// rtl/minute_counter60.sv - BCD mod-60 time and alarm minute counters with carry and alarm-hit pulses
// Optional feature macro: SET_CARRY_EN (manual 59->00 wraps also pulse carry_clock).
module minute_counter60 #(
  parameter int RST_CLOCK_MIN = 0,
  parameter int RST_ALARM_MIN = 0
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       min_tick,
  input  logic       up_clock60,
  input  logic       up_alarm60,
  output logic [3:0] clk_units,
  output logic [2:0] clk_tens,
  output logic [3:0] alm_units,
  output logic [2:0] alm_tens,
  output logic       carry_clock,
  output logic       alarm_hit
);

  localparam logic [3:0] RST_CLK_U = 4'(RST_CLOCK_MIN % 10);
  localparam logic [2:0] RST_CLK_T = 3'(RST_CLOCK_MIN / 10);
  localparam logic [3:0] RST_ALM_U = 4'(RST_ALARM_MIN % 10);
  localparam logic [2:0] RST_ALM_T = 3'(RST_ALARM_MIN / 10);

  // Returns {tens, units} of the BCD minute value plus one, wrapping 59 -> 00.
  function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] units);
    logic [2:0] t;
    logic [3:0] u;
    t = tens;
    u = units;
    if (u >= 4'd9) begin
      u = 4'd0;
      if (t >= 3'd5) t = 3'd0;
      else t = 3'(t + 3'd1);
    end else begin
      u = 4'(u + 4'd1);
    end
    return {t, u};
  endfunction

  logic [3:0] clk_units_q, clk_units_d;
  logic [2:0] clk_tens_q, clk_tens_d;
  logic [3:0] alm_units_q, alm_units_d;
  logic [2:0] alm_tens_q, alm_tens_d;
  logic       pend_q, pend_d;
  logic       carry_q, carry_d;
  logic       hit_q, hit_d;
  logic       time_inc;
  logic       time_at_max;

  always_comb begin
    clk_units_d = clk_units_q;
    clk_tens_d  = clk_tens_q;
    alm_units_d = alm_units_q;
    alm_tens_d  = alm_tens_q;

    // Any source yields exactly one increment; the tick wins and a clashing
    // manual strobe waits in the pending flag.
    time_inc    = min_tick | pend_q | up_clock60;
    time_at_max = (clk_tens_q >= 3'd5) && (clk_units_q >= 4'd9);

    if (time_inc) begin
      {clk_tens_d, clk_units_d} = bcd_inc(clk_tens_q, clk_units_q);
    end
    if (up_alarm60) begin
      {alm_tens_d, alm_units_d} = bcd_inc(alm_tens_q, alm_units_q);
    end

    if (min_tick) pend_d = pend_q | up_clock60;
    else          pend_d = pend_q & up_clock60;

`ifdef SET_CARRY_EN
    carry_d = time_inc && time_at_max;
`else
    carry_d = min_tick && time_at_max;
`endif

    hit_d = min_tick && ({clk_tens_d, clk_units_d} == {alm_tens_d, alm_units_d});
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      clk_units_q <= RST_CLK_U;
      clk_tens_q  <= RST_CLK_T;
      alm_units_q <= RST_ALM_U;
      alm_tens_q  <= RST_ALM_T;
      pend_q      <= 1'b0;
      carry_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      clk_units_q <= clk_units_d;
      clk_tens_q  <= clk_tens_d;
      alm_units_q <= alm_units_d;
      alm_tens_q  <= alm_tens_d;
      pend_q      <= pend_d;
      carry_q     <= carry_d;
      hit_q       <= hit_d;
    end
  end

  assign clk_units   = clk_units_q;
  assign clk_tens    = clk_tens_q;
  assign alm_units   = alm_units_q;
  assign alm_tens    = alm_tens_q;
  assign carry_clock = carry_q;
  assign alarm_hit   = hit_q;

endmodule

// File: tb/tb_minute_counter60.sv
// tb/tb_minute_counter60.sv - directed table and sequence checks for minute_counter60
module tb_minute_counter60;

  logic       ck;
  logic       reset;
  logic       min_tick;
  logic       up_clock60;
  logic       up_alarm60;
  logic [3:0] clk_units;
  logic [2:0] clk_tens;
  logic [3:0] alm_units;
  logic [2:0] alm_tens;
  logic       carry_clock;
  logic       alarm_hit;

  int total = 0;
  int bad   = 0;

`ifdef SET_CARRY_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  minute_counter60 #(.RST_CLOCK_MIN(0), .RST_ALARM_MIN(0)) dut (
    .ck(ck), .reset(reset), .min_tick(min_tick), .up_clock60(up_clock60),
    .up_alarm60(up_alarm60), .clk_units(clk_units), .clk_tens(clk_tens),
    .alm_units(alm_units), .alm_tens(alm_tens), .carry_clock(carry_clock),
    .alarm_hit(alarm_hit)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic r, t, u, a;
    int   ec, ea;
    logic car, hit;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic step(input logic r, t, u, a, input int ec, ea, input logic car, hit);
    int clk_val, alm_val;
    reset = r; min_tick = t; up_clock60 = u; up_alarm60 = a;
    @(posedge ck);
    #1;
    clk_val = (clk_tens > 3'd5 || clk_units > 4'd9) ? -1 : int'(clk_tens) * 10 + int'(clk_units);
    alm_val = (alm_tens > 3'd5 || alm_units > 4'd9) ? -1 : int'(alm_tens) * 10 + int'(alm_units);
    chk("clock", clk_val, ec);
    chk("alarm", alm_val, ea);
    chk("carry", int'(carry_clock), int'(car));
    chk("hit", int'(alarm_hit), int'(hit));
  endtask

  initial begin
    reset = 1'b1; min_tick = 1'b0; up_clock60 = 1'b0; up_alarm60 = 1'b0;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 2, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 2, 1, 0, 0};
    tbl[5] = '{0, 1, 1, 0, 3, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 4, 1, 0, 0};
    tbl[7] = '{0, 0, 1, 1, 5, 2, 0, 0};
    tbl[8] = '{0, 1, 0, 1, 6, 3, 0, 0};
    tbl[9] = '{1, 0, 1, 1, 0, 0, 0, 0};

    @(negedge ck);
    for (int i = 0; i < 10; i++)
      step(tbl[i].r, tbl[i].t, tbl[i].u, tbl[i].a, tbl[i].ec, tbl[i].ea, tbl[i].car, tbl[i].hit);

    // Tick-driven wrap 58 -> 59 -> 00 with carry; alarm parked at 01.
    step(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 58; i++) step(0, 0, 1, 0, i + 1, 1, 0, 0);
    step(0, 1, 0, 0, 59, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Manual hold 55 -> 07 across the wrap.
    for (int i = 0; i < 55; i++) step(0, 0, 1, 0, i + 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int m;
      m = (55 + i + 1) % 60;
      step(0, 0, 1, 0, m, 1, SC && (m == 0), 0);
    end
    step(0, 0, 0, 0, 7, 1, 0, 0);

    // Single coincident tick+strobe at 10.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, i + 1, 1, 0, 0);
    step(0, 1, 1, 0, 11, 1, 0, 0);
    step(0, 0, 0, 0, 12, 1, 0, 0);
    step(0, 0, 0, 0, 12, 1, 0, 0);

    // Two back-to-back coincident cycles: the second strobe is dropped.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, i + 1, 1, 0, 0);
    step(0, 1, 1, 0, 11, 1, 0, 0);
    step(0, 1, 1, 0, 12, 1, 0, 0);
    step(0, 0, 0, 0, 13, 1, 0, 0);
    step(0, 0, 0, 0, 13, 1, 0, 0);

    // Alarm hit on tick at 30, then alarm wraps back to 00.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0, i + 1, 0, 0);
    for (int i = 0; i < 29; i++) step(0, 0, 1, 0, i + 1, 30, 0, 0);
    step(0, 1, 0, 0, 30, 30, 0, 1);
    step(0, 0, 0, 0, 30, 30, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 30, (30 + i + 1) % 60, 0, 0);

    // Manual arrival at the alarm minute never hits.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0, i + 1, 0, 0);
    for (int i = 0; i < 29; i++) step(0, 0, 1, 0, i + 1, 30, 0, 0);
    step(0, 0, 1, 0, 30, 30, 0, 0);
    step(0, 0, 0, 0, 30, 30, 0, 0);

    // Reset mid-run clears counters and a pending strobe.
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
